// File: rtl/rv32i_single_core.sv
// Single-cycle RV32I-subset core: each rising edge fetches, executes and retires one instruction.
// Instruction ROM, register file and data memory are instanced as instructions/regfile/datamem.

module rv32i_imem #(
    parameter int WORDS = 256
) (
    input  logic [$clog2(WORDS)-1:0] i_addr,
    output logic [31:0]              o_data
);
    // Contents are loaded through hierarchy; the core only reads them.
    logic [31:0] mem [0:WORDS-1];

    assign o_data = mem[i_addr];
endmodule

module rv32i_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [4:0]  i_rd,
    input  logic        i_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (i_we && (i_rd != 5'd0)) begin
            rf[i_rd] <= i_wdata;
        end
    end

    assign o_rs1_data = (i_rs1 == 5'd0) ? '0 : rf[i_rs1];
    assign o_rs2_data = (i_rs2 == 5'd0) ? '0 : rf[i_rs2];
endmodule

module rv32i_dmem #(
    parameter int WORDS = 256
) (
    input  logic                     clk,
    input  logic [$clog2(WORDS)-1:0] i_addr,
    input  logic                     i_we,
    input  logic [31:0]              i_wdata,
    output logic [31:0]              o_rdata
);
    logic [31:0] mem [0:WORDS-1];

    always_ff @(posedge clk) begin
        if (i_we) mem[i_addr] <= i_wdata;
    end

    assign o_rdata = mem[i_addr];
endmodule

module rv32i_single_core #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input logic clk,
    input logic reset
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [31:0] pc;
    logic [31:0] w_instr, w_rs1_data, w_rs2_data, w_dmem_rdata;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    logic [31:0] w_alu_b, w_alu_res, w_sra, w_mem_addr;
    logic [31:0] w_rd_data, w_pc_plus4, w_pc_next;
    logic [6:0]  w_opcode, w_funct7;
    logic [2:0]  w_funct3;
    logic        w_rd_we, w_dmem_we, w_eq;
    logic        w_unused;

    rv32i_imem #(.WORDS(IMEM_WORDS)) instructions (
        .i_addr (pc[IAW+1:2]),
        .o_data (w_instr)
    );

    rv32i_regfile regfile (
        .clk        (clk),
        .reset      (reset),
        .i_rs1      (w_instr[19:15]),
        .i_rs2      (w_instr[24:20]),
        .i_rd       (w_instr[11:7]),
        .i_we       (w_rd_we),
        .i_wdata    (w_rd_data),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data)
    );

    rv32i_dmem #(.WORDS(DMEM_WORDS)) datamem (
        .clk     (clk),
        .i_addr  (w_mem_addr[DAW+1:2]),
        .i_we    (w_dmem_we),
        .i_wdata (w_rs2_data),
        .o_rdata (w_dmem_rdata)
    );

    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];
    assign w_funct7 = w_instr[31:25];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'b0};

    assign w_alu_b    = (w_opcode == OP_R) ? w_rs2_data : w_imm_i;
    assign w_sra      = $signed(w_rs1_data) >>> w_alu_b[4:0];
    assign w_mem_addr = w_rs1_data + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);
    assign w_pc_plus4 = pc + 32'd4;
    assign w_eq       = (w_rs1_data == w_rs2_data);

    always_comb begin
        w_alu_res = w_rs1_data & w_alu_b;
        case (w_funct3)
            3'b000: w_alu_res = (w_opcode == OP_R && w_funct7[5]) ? w_rs1_data - w_alu_b
                                                                  : w_rs1_data + w_alu_b;
            3'b001: w_alu_res = w_rs1_data << w_alu_b[4:0];
            3'b010: w_alu_res = {31'b0, $signed(w_rs1_data) < $signed(w_alu_b)};
            3'b011: w_alu_res = {31'b0, w_rs1_data < w_alu_b};
            3'b100: w_alu_res = w_rs1_data ^ w_alu_b;
            3'b101: w_alu_res = w_funct7[5] ? w_sra : (w_rs1_data >> w_alu_b[4:0]);
            3'b110: w_alu_res = w_rs1_data | w_alu_b;
            default: w_alu_res = w_rs1_data & w_alu_b;
        endcase
    end

    // Anything not recognised below (including SLTIU, byte/half memory ops) retires as a NOP.
    always_comb begin
        w_rd_we   = 1'b0;
        w_dmem_we = 1'b0;
        w_rd_data = w_alu_res;
        w_pc_next = w_pc_plus4;
        case (w_opcode)
            OP_R: w_rd_we = (w_funct7 == 7'h00) ||
                            (w_funct7 == 7'h20 && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
            OP_I: begin
                case (w_funct3)
                    3'b011:  w_rd_we = 1'b0;
                    3'b001:  w_rd_we = (w_funct7 == 7'h00);
                    3'b101:  w_rd_we = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
                    default: w_rd_we = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_rd_we   = (w_funct3 == 3'b010);
                w_rd_data = w_dmem_rdata;
            end
            OP_STORE: w_dmem_we = (w_funct3 == 3'b010) && reset;
            OP_BRANCH: begin
                if ((w_funct3 == 3'b000 && w_eq) || (w_funct3 == 3'b001 && !w_eq))
                    w_pc_next = pc + w_imm_b;
            end
            OP_JAL: begin
                w_rd_we   = 1'b1;
                w_rd_data = w_pc_plus4;
                w_pc_next = pc + w_imm_j;
            end
            OP_LUI: begin
                w_rd_we   = 1'b1;
                w_rd_data = w_imm_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc <= '0;
        else        pc <= w_pc_next;
    end

    assign w_unused = ^{pc[1:0], pc[31:IAW+2], w_mem_addr[1:0], w_mem_addr[31:DAW+2]};
endmodule

// File: tb/tb_rv32i_single_core.sv
// Scenario bench for rv32i_single_core: programs are loaded into the ROM through hierarchy
// and architectural state is compared against a queue of expected values.

module tb_rv32i_single_core;
    localparam logic [6:0] OPI = 7'h13;
    localparam logic [6:0] OPR = 7'h33;
    localparam logic [6:0] OPL = 7'h03;
    localparam logic [6:0] OPU = 7'h37;
    localparam int K_REG = 0;
    localparam int K_MEM = 1;
    localparam int K_PC  = 2;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        reset;
    int          n_checks;
    int          n_pass;
    exp_t        sb[$];
    logic [31:0] prog[$];

    rv32i_single_core #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
        .clk   (clk),
        .reset (reset)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPR};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
    endfunction

    function automatic logic [31:0] probe(input int kind, input int idx);
        case (kind)
            K_REG:   return dut.regfile.rf[idx];
            K_MEM:   return dut.datamem.mem[idx];
            default: return dut.pc;
        endcase
    endfunction

    task automatic tick();
        clk = 1'b1;
        #5;
        clk = 1'b0;
        #5;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input string name, input int kind, input int idx, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic load_and_restart();
        for (int i = 0; i < 256; i++)
            dut.instructions.mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] got;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        #3;
        reset = 1'b0;
        #3;
        reset = 1'b1;
        #3;
        push("reset_pc", K_PC, 0, 32'h0);
        for (int i = 1; i < 32; i++) push($sformatf("reset_x%0d", i), K_REG, i, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = probe(e.kind, e.idx);
            n_checks++;
            if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_alu();
        exp_t        e;
        logic [31:0] got;
        prog = '{enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI),
                 enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OPI),
                 enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3),
                 enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4),
                 enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5),
                 enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPI)};
        load_and_restart();
        push("alu_x1", K_REG, 1, 32'd5);
        push("alu_x2", K_REG, 2, 32'hFFFF_FFFD);
        push("alu_x3", K_REG, 3, 32'd2);
        push("alu_x4", K_REG, 4, 32'd8);
        push("alu_x5", K_REG, 5, 32'd1);
        push("alu_x0", K_REG, 0, 32'd0);
        push("alu_pc", K_PC, 0, 32'd24);
        ticks(6);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = probe(e.kind, e.idx);
            n_checks++;
            if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_alu_logic();
        exp_t        e;
        logic [31:0] got;
        prog = '{enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI),
                 enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OPI),
                 enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3),
                 enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd4),
                 enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd5),
                 enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd6),
                 enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd7),
                 enc_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd8),
                 enc_r(7'h20, 5'd1, 5'd2, 3'b101, 5'd9),
                 enc_i(12'h0F0, 5'd2, 3'b111, 5'd10, OPI),
                 enc_i(12'h100, 5'd1, 3'b110, 5'd11, OPI),
                 enc_i(12'hFFF, 5'd1, 3'b100, 5'd12, OPI),
                 enc_i(12'h000, 5'd2, 3'b010, 5'd13, OPI),
                 enc_i(12'h01F, 5'd1, 3'b001, 5'd14, OPI),
                 enc_r(7'h00, 5'd2, 5'd1, 3'b011, 5'd15)};
        load_and_restart();
        push("xor",    K_REG, 3,  32'hFFFF_FFF8);
        push("or",     K_REG, 4,  32'hFFFF_FFFD);
        push("and",    K_REG, 5,  32'h0000_0005);
        push("sltu_0", K_REG, 6,  32'h0);
        push("sll",    K_REG, 7,  32'h0000_00A0);
        push("srl",    K_REG, 8,  32'h07FF_FFFF);
        push("sra",    K_REG, 9,  32'hFFFF_FFFF);
        push("andi",   K_REG, 10, 32'h0000_00F0);
        push("ori",    K_REG, 11, 32'h0000_0105);
        push("xori",   K_REG, 12, 32'hFFFF_FFFA);
        push("slti",   K_REG, 13, 32'h1);
        push("slli",   K_REG, 14, 32'h8000_0000);
        push("sltu_1", K_REG, 15, 32'h1);
        push("logic_pc", K_PC, 0, 32'd60);
        ticks(15);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = probe(e.kind, e.idx);
            n_checks++;
            if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_memory();
        exp_t        e;
        logic [31:0] got;
        prog = '{enc_i(12'h055, 5'd0, 3'b000, 5'd1, OPI),
                 enc_s(12'd8, 5'd1, 5'd0),
                 enc_i(12'd8, 5'd0, 3'b010, 5'd2, OPL),
                 enc_s(12'h404, 5'd1, 5'd0),
                 enc_i(12'hC04, 5'd0, 3'b010, 5'd3, OPL),
                 enc_i(12'd9, 5'd0, 3'b010, 5'd4, OPL)};
        load_and_restart();
        push("sw_mem2", K_MEM, 2, 32'h55);
        push("lw_x2",   K_REG, 2, 32'h55);
        ticks(3);
        for (int step = 0; step < 2; step++) begin
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = probe(e.kind, e.idx);
                n_checks++;
                if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                else n_pass++;
            end
            if (step == 0) begin
                push("sw_wrap_mem1",  K_MEM, 1, 32'h55);
                push("lw_wrap_neg",   K_REG, 3, 32'h55);
                push("lw_byteoffset", K_REG, 4, 32'h55);
                ticks(3);
            end
        end
    endtask

    task automatic test_branch_jump();
        exp_t        e;
        logic [31:0] got;
        logic [31:0] exp_pc [4];
        exp_pc = '{32'd4, 32'd8, 32'd16, 32'd4};
        prog = '{enc_i(12'd1, 5'd0, 3'b000, 5'd1, OPI),
                 enc_b(13'd8, 5'd0, 5'd1, 3'b000),
                 enc_b(13'd8, 5'd0, 5'd1, 3'b001),
                 enc_i(12'd9, 5'd0, 3'b000, 5'd6, OPI),
                 enc_j(21'h1FFFF4, 5'd5)};
        load_and_restart();
        for (int s = 0; s < 4; s++) begin
            push($sformatf("br_pc_step%0d", s + 1), K_PC, 0, exp_pc[s]);
            tick();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = probe(e.kind, e.idx);
                n_checks++;
                if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                else n_pass++;
            end
        end
        push("jal_link_x5",  K_REG, 5, 32'd20);
        push("skipped_x6",   K_REG, 6, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = probe(e.kind, e.idx);
            n_checks++;
            if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_lui_shift();
        exp_t        e;
        logic [31:0] got;
        prog = '{{20'h80000, 5'd1, OPU},
                 enc_i(12'h404, 5'd1, 3'b101, 5'd2, OPI),
                 enc_i(12'h004, 5'd1, 3'b101, 5'd3, OPI)};
        load_and_restart();
        push("lui_x1",  K_REG, 1, 32'h8000_0000);
        push("srai_x2", K_REG, 2, 32'hF800_0000);
        push("srli_x3", K_REG, 3, 32'h0800_0000);
        ticks(3);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = probe(e.kind, e.idx);
            n_checks++;
            if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_illegal_nop();
        exp_t        e;
        logic [31:0] got;
        prog = '{enc_i(12'd3, 5'd0, 3'b000, 5'd1, OPI),
                 32'h0000_0000,
                 enc_i(12'd5, 5'd0, 3'b011, 5'd2, OPI),
                 enc_r(7'h01, 5'd1, 5'd1, 3'b000, 5'd3),
                 enc_i(12'd1, 5'd0, 3'b000, 5'd4, OPI)};
        load_and_restart();
        push("nop_sltiu_x2", K_REG, 2, 32'd0);
        push("nop_f7_x3",    K_REG, 3, 32'd0);
        push("nop_after_x4", K_REG, 4, 32'd1);
        push("nop_pc",       K_PC,  0, 32'd20);
        ticks(5);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got = probe(e.kind, e.idx);
            n_checks++;
            if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t        e;
        logic [31:0] got;
        prog = '{enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI),
                 enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, OPI),
                 enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3)};
        load_and_restart();
        ticks(3);
        for (int phase = 0; phase < 4; phase++) begin
            case (phase)
                0: begin
                    reset = 1'b0;
                    #1;
                    push("mid_pc_async", K_PC, 0, 32'd0);
                    push("mid_x1_async", K_REG, 1, 32'd0);
                    push("mid_x2_async", K_REG, 2, 32'd0);
                    push("mid_x3_async", K_REG, 3, 32'd0);
                end
                1: begin
                    tick();
                    push("mid_pc_held", K_PC, 0, 32'd0);
                    push("mid_x1_held", K_REG, 1, 32'd0);
                end
                2: begin
                    reset = 1'b1;
                    #1;
                    tick();
                    push("restart_pc", K_PC, 0, 32'd4);
                    push("restart_x1", K_REG, 1, 32'd5);
                    push("restart_x2", K_REG, 2, 32'd0);
                end
                default: begin
                    tick();
                    push("restart2_pc", K_PC, 0, 32'd8);
                    push("restart2_x2", K_REG, 2, 32'hFFFF_FFFD);
                end
            endcase
            while (sb.size() > 0) begin
                e = sb.pop_front();
                got = probe(e.kind, e.idx);
                n_checks++;
                if (got !== e.exp) $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
                else n_pass++;
            end
        end
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b0;
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_alu();
        test_alu_logic();
        test_memory();
        test_branch_jump();
        test_lui_shift();
        test_illegal_nop();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
